// File: rtl/decode_stage_pkg.sv
// Shared decode definitions: base opcode map, datapath-width constants and
// the shift-amount width helper used by the immediate generator.
package single_cycle_defs;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

  typedef enum logic [6:0] {
    LOAD_I = 7'b0000011,
    I_TYPE = 7'b0010011,
    AUIPC  = 7'b0010111,
    S_TYPE = 7'b0100011,
    R_TYPE = 7'b0110011,
    LUI_I  = 7'b0110111,
    B_TYPE = 7'b1100011,
    JALR_I = 7'b1100111,
    J_TYPE = 7'b1101111
  } type_opcode_e;

  function automatic int shamt_width(input int xlen);
    return (xlen == XLEN_64) ? 6 : 5;
  endfunction

  function automatic logic is_known_opcode(input logic [6:0] op);
    case (op)
      LOAD_I, I_TYPE, AUIPC, S_TYPE, R_TYPE,
      LUI_I, B_TYPE, JALR_I, J_TYPE: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational immediate generator; also reports RV32 shifts whose shamt
// would need bit 25, which are illegal at that width.
module imm_gen
  import single_cycle_defs::*;
#(
  parameter int XLEN = XLEN_32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] imm_o,
  output logic            shift_illegal_o
);

  localparam int SHW = shamt_width(XLEN);

  logic is_shift;
  assign is_shift = (instr_i[14:12] == 3'b001) || (instr_i[14:12] == 3'b101);

  always_comb begin
    imm_o           = '0;
    shift_illegal_o = 1'b0;
    case (instr_i[6:0])
      I_TYPE: begin
        if (is_shift) begin
          imm_o[SHW-1:0]  = instr_i[20 +: SHW];
          shift_illegal_o = (XLEN == XLEN_32) && instr_i[25];
        end else begin
          imm_o = XLEN'($signed(instr_i[31:20]));
        end
      end
      LOAD_I, JALR_I: imm_o = XLEN'($signed(instr_i[31:20]));
      S_TYPE: imm_o = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
      B_TYPE: imm_o = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                     instr_i[11:8], 1'b0}));
      J_TYPE: imm_o = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                     instr_i[30:21], 1'b0}));
      LUI_I, AUIPC: imm_o = XLEN'($signed({instr_i[31:12], 12'h000}));
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: decodes on the input side and buffers decoded
// bundles in a DEPTH-entry FIFO toward execute, with flush for redirects.
module decode_stage
  import single_cycle_defs::*;
#(
  parameter int XLEN  = XLEN_32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_instr,
  input  logic [XLEN-1:0]        in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output type_opcode_e           out_opcode,
  output logic [2:0]             out_funct3,
  output logic [6:0]             out_funct7,
  output logic [4:0]             out_rd,
  output logic [4:0]             out_rs1,
  output logic [4:0]             out_rs2,
  output logic [XLEN-1:0]        out_imm,
  output logic                   out_illegal,
  output logic [$clog2(DEPTH):0] out_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic            illegal;
  } entry_t;

  logic [XLEN-1:0] gen_imm;
  logic            shift_illegal;
  entry_t          in_entry;

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i         (in_instr),
    .imm_o           (gen_imm),
    .shift_illegal_o (shift_illegal)
  );

  always_comb begin
    in_entry.pc      = in_pc;
    in_entry.opcode  = in_instr[6:0];
    in_entry.funct3  = in_instr[14:12];
    in_entry.funct7  = in_instr[31:25];
    in_entry.rd      = in_instr[11:7];
    in_entry.rs1     = in_instr[19:15];
    in_entry.rs2     = in_instr[24:20];
    in_entry.illegal = (in_instr[1:0] != 2'b11) || !is_known_opcode(in_instr[6:0])
                       || shift_illegal;
    // Illegal words still travel down the pipe, but never with a stray immediate.
    in_entry.imm     = in_entry.illegal ? '0 : gen_imm;
  end

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  // in_ready depends only on registered occupancy, keeping out_ready off that path.
  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_entry;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  entry_t head;
  assign head        = mem_q[rd_ptr_q];
  assign out_pc      = head.pc;
  assign out_opcode  = type_opcode_e'(head.opcode);
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;
  assign out_count   = count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: RV32 and RV64 instances driven in lockstep, checked
// against a table of hand-decoded words, corner sequences and a random scoreboard.
module tb_decode_stage;
  import single_cycle_defs::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_instr = '0;
  logic [63:0] in_pc = '0;

  logic a_in_ready, a_out_valid, a_illegal;
  logic b_in_ready, b_out_valid, b_illegal;
  logic [31:0] a_pc, a_imm;
  logic [63:0] b_pc, b_imm;
  type_opcode_e a_op, b_op;
  logic [2:0] a_f3, b_f3;
  logic [6:0] a_f7, b_f7;
  logic [4:0] a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
  logic [1:0] a_count, b_count;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(2)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_pc(a_pc), .out_opcode(a_op), .out_funct3(a_f3), .out_funct7(a_f7), .out_rd(a_rd),
    .out_rs1(a_rs1), .out_rs2(a_rs2), .out_imm(a_imm), .out_illegal(a_illegal),
    .out_count(a_count)
  );

  decode_stage #(.XLEN(64), .DEPTH(2)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_pc(b_pc), .out_opcode(b_op), .out_funct3(b_f3), .out_funct7(b_f7), .out_rd(b_rd),
    .out_rs1(b_rs1), .out_rs2(b_rs2), .out_imm(b_imm), .out_illegal(b_illegal),
    .out_count(b_count)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Occupancy-derived handshake state, same for both widths.
  task automatic chk_state(input string tag, input int cnt);
    chk({tag, " count32"}, 64'(a_count), 64'(cnt));
    chk({tag, " count64"}, 64'(b_count), 64'(cnt));
    chk({tag, " valid32"}, 64'(a_out_valid), 64'(cnt != 0));
    chk({tag, " valid64"}, 64'(b_out_valid), 64'(cnt != 0));
    chk({tag, " ready32"}, 64'(a_in_ready), 64'(cnt < 2));
    chk({tag, " ready64"}, 64'(b_in_ready), 64'(cnt < 2));
  endtask

  task automatic chk_fields(input string tag, input logic [31:0] w, input logic [63:0] pc);
    chk({tag, " pc32"}, 64'(a_pc), 64'(pc[31:0]));
    chk({tag, " pc64"}, b_pc, pc);
    chk({tag, " op"}, 64'({a_op, b_op}), 64'({w[6:0], w[6:0]}));
    chk({tag, " f3"}, 64'({a_f3, b_f3}), 64'({w[14:12], w[14:12]}));
    chk({tag, " f7"}, 64'({a_f7, b_f7}), 64'({w[31:25], w[31:25]}));
    chk({tag, " rd"}, 64'({a_rd, b_rd}), 64'({w[11:7], w[11:7]}));
    chk({tag, " rs1"}, 64'({a_rs1, b_rs1}), 64'({w[19:15], w[19:15]}));
    chk({tag, " rs2"}, 64'({a_rs2, b_rs2}), 64'({w[24:20], w[24:20]}));
  endtask

  function automatic longint sx(input longint field, input int bits);
    longint half = longint'(1) << (bits - 1);
    return (field >= half) ? field - (half * 2) : field;
  endfunction

  // Reference decode from the instruction-set rules: returns {illegal, imm}.
  function automatic logic [64:0] ref_decode(input logic [31:0] w, input int xlen);
    int     known[9] = '{'h03, 'h13, 'h17, 'h23, 'h33, 'h37, 'h63, 'h67, 'h6f};
    int     op = int'(w[6:0]);
    int     f3 = int'(w[14:12]);
    bit     ill = (w[1:0] != 2'b11);
    bit     found = 0;
    longint v = 0;
    foreach (known[i]) if (known[i] == op) found = 1;
    if (!found) ill = 1;
    case (op)
      'h13: begin
        if (f3 == 1 || f3 == 5) begin
          if (xlen == 32) begin
            v = longint'(w[24:20]);
            if (w[25]) ill = 1;
          end else begin
            v = longint'(w[25:20]);
          end
        end else v = sx(longint'(w[31:20]), 12);
      end
      'h03, 'h67: v = sx(longint'(w[31:20]), 12);
      'h23: v = sx(longint'({w[31:25], w[11:7]}), 12);
      'h63: v = sx(longint'({w[31], w[7], w[30:25], w[11:8], 1'b0}), 13);
      'h6f: v = sx(longint'({w[31], w[19:12], w[20], w[30:21], 1'b0}), 21);
      'h37, 'h17: v = sx(longint'(w[31:12]), 20) * 4096;
      default: v = 0;
    endcase
    if (ill) v = 0;
    return {ill, 64'(v)};
  endfunction

  task automatic chk_model(input string tag, input logic [31:0] w, input logic [63:0] pc);
    logic [64:0] r32, r64;
    r32 = ref_decode(w, 32);
    r64 = ref_decode(w, 64);
    chk_fields(tag, w, pc);
    chk({tag, " imm32"}, 64'(a_imm), 64'(r32[31:0]));
    chk({tag, " imm64"}, b_imm, r64[63:0]);
    chk({tag, " ill"}, 64'({a_illegal, b_illegal}), 64'({r32[64], r64[64]}));
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm32;
    bit          ill32;
    logic [63:0] imm64;
    bit          ill64;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] qi[$];
  logic [63:0] qp[$];

  function automatic logic [31:0] rand_instr();
    int          ops[9] = '{'h03, 'h13, 'h17, 'h23, 'h33, 'h37, 'h63, 'h67, 'h6f};
    logic [31:0] r = $urandom();
    if ($urandom_range(0, 7) == 0) return r;
    return {r[31:7], 7'(ops[$urandom_range(0, 8)])};
  endfunction

  task automatic push_word(input logic [31:0] w, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = w;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    vecs.push_back('{32'hFFF00093, 32'hFFFFFFFF, 0, 64'hFFFFFFFFFFFFFFFF, 0}); // addi -1
    vecs.push_back('{32'h02131293, 32'h0,        1, 64'd33,               0}); // slli 33
    vecs.push_back('{32'h800000B7, 32'h80000000, 0, 64'hFFFFFFFF80000000, 0}); // lui
    vecs.push_back('{32'h00000000, 32'h0,        1, 64'h0,                1});
    vecs.push_back('{32'hFE20AE23, 32'hFFFFFFFC, 0, 64'hFFFFFFFFFFFFFFFC, 0}); // sw -4
    vecs.push_back('{32'h00000463, 32'h8,        0, 64'h8,                0}); // beq +8
    vecs.push_back('{32'hFE000EE3, 32'hFFFFFFFC, 0, 64'hFFFFFFFFFFFFFFFC, 0}); // beq -4
    vecs.push_back('{32'hFFFFF06F, 32'hFFFFFFFE, 0, 64'hFFFFFFFFFFFFFFFE, 0}); // jal -2
    vecs.push_back('{32'h003100B3, 32'h0,        0, 64'h0,                0}); // add
    vecs.push_back('{32'h4030D093, 32'h3,        0, 64'h3,                0}); // srai 3
    vecs.push_back('{32'h0000007F, 32'h0,        1, 64'h0,                1}); // unknown op
    vecs.push_back('{32'h00000001, 32'h0,        1, 64'h0,                1}); // low bits 01
    vecs.push_back('{32'h12345097, 32'h12345000, 0, 64'h12345000,         0}); // auipc
    vecs.push_back('{32'h80002083, 32'hFFFFF800, 0, 64'hFFFFFFFFFFFFF800, 0}); // lw -2048
    vecs.push_back('{32'h000080E7, 32'h0,        0, 64'h0,                0}); // jalr

    // Reset state.
    repeat (2) @(negedge clk);
    chk_state("reset", 0);
    chk("reset pc64", b_pc, 64'h0);
    chk("reset imm64", b_imm, 64'h0);
    chk("reset imm32", 64'(a_imm), 64'h0);
    chk("reset ill", 64'({a_illegal, b_illegal}), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one word at a time, consumed immediately.
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      logic [63:0] pc = {$urandom(), $urandom() & 32'hFFFF_FFFC};
      string tag = $sformatf("vec%0d", i);
      push_word(vecs[i].instr, pc);
      chk_state(tag, 1);
      chk_fields(tag, vecs[i].instr, pc);
      chk({tag, " imm32"}, 64'(a_imm), 64'(vecs[i].imm32));
      chk({tag, " ill32"}, 64'(a_illegal), 64'(vecs[i].ill32));
      chk({tag, " imm64"}, b_imm, vecs[i].imm64);
      chk({tag, " ill64"}, 64'(b_illegal), 64'(vecs[i].ill64));
      $display("vector %0d instr=%08h imm32=%08h imm64=%016h", i, vecs[i].instr, a_imm, b_imm);
      @(negedge clk);
    end

    // Back-pressure: fill, hold the third, then drain in order.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00100093; in_pc = 64'h100;
    @(negedge clk); chk_state("fill1", 1);
    in_instr  = 32'h00200113; in_pc = 64'h104;
    @(negedge clk); chk_state("fill2", 2);
    in_instr  = 32'h00300193; in_pc = 64'h108;
    @(negedge clk); chk_state("fill3 held", 2);
    chk("fill head", b_pc, 64'h100);
    out_ready = 1'b1;
    @(negedge clk); chk_state("pop1", 1);
    chk("pop1 head", b_pc, 64'h104);
    chk("pop1 head32", 64'(a_pc), 64'h104);
    @(negedge clk); chk_state("pop2 push3", 1);
    chk("third head", b_pc, 64'h108);
    chk("third rd", 64'(a_rd), 64'd3);
    in_valid = 1'b0;
    @(negedge clk); chk_state("drained", 0);
    $display("backpressure sequence done");

    // Flush beats a simultaneous push and pop.
    out_ready = 1'b0;
    push_word(32'h00100093, 64'h200);
    push_word(32'h00200113, 64'h204);
    chk_state("preflush", 2);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h00500293; in_pc = 64'h208;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk_state("flush", 0);
    @(negedge clk);
    chk_state("postflush", 0);
    $display("flush sequence done");

    // Asynchronous reset with entries buffered.
    out_ready = 1'b0;
    push_word(32'h00000000, 64'h300);
    chk("zero word ill", 64'({a_illegal, b_illegal}), 64'h3);
    push_word(32'h00100093, 64'h304);
    chk_state("prereset", 2);
    #2 rst_n = 1'b0;
    #1;
    chk_state("async reset", 0);
    chk("async reset pc", b_pc, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_state("after reset", 0);
    $display("async reset sequence done");

    // Random traffic against a queue scoreboard.
    for (int cyc = 0; cyc < 600; cyc++) begin
      bit do_push, do_pop;
      chk_state($sformatf("rnd%0d", cyc), qi.size());
      if (qi.size() > 0) chk_model($sformatf("rnd%0d", cyc), qi[0], qp[0]);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_instr  = rand_instr();
      in_pc     = {$urandom(), $urandom()};
      do_push = in_valid && (qi.size() < 2) && !flush;
      do_pop  = out_ready && (qi.size() > 0) && !flush;
      if (flush) begin
        qi.delete();
        qp.delete();
      end else begin
        if (do_pop) begin
          void'(qi.pop_front());
          void'(qp.pop_front());
        end
        if (do_push) begin
          qi.push_back(in_instr);
          qp.push_back(in_pc);
        end
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    flush    = 1'b0;
    $display("random phase done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
